// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the serial instruction-memory loader.
// The CHK state is only reachable when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WR,
        CHK,
        FIN
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int HDR_W      = 8;

endpackage

// File: rtl/imem_loader_if.sv
// Instruction-memory write port driven by the loader.
// The loader side is the master; the memory side is the slave.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        input imem_we,
        input imem_addr,
        input imem_wdata
    );
endinterface

// File: rtl/imem_loader_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// The edge pulse is high for exactly one clk cycle.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic evt
);
    // sh[0], sh[1] synchronize; sh[2] holds the previous synchronized level
    logic [2:0] sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh <= '0;
        end else begin
            sh <= {sh[1:0], pin};
        end
    end

    assign evt = sh[1] & ~sh[2];
endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte stream to little-endian instruction words.
// Define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_start,
    input  logic             byte_strobe,
    input  logic [HDR_W-1:0] byte_in,
    imem_loader_if.master    mem,
    output logic             cpu_hold,
    output logic             cpu_restart,
    output logic             done,
    output logic             err
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int IDX_W = ADDR_W + 1;

    logic             start_evt;
    logic             byte_evt;
    state_t           state;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] n_words;
    logic [1:0]       byte_cnt;
    logic [23:0]      asm_q;

    sync_edge u_start (
        .clk   (clk),
        .reset (reset),
        .pin   (load_start),
        .evt   (start_evt)
    );

    sync_edge u_byte (
        .clk   (clk),
        .reset (reset),
        .pin   (byte_strobe),
        .evt   (byte_evt)
    );

    function automatic logic [IDX_W-1:0] clamp_len(
        input logic [HDR_W-1:0] b
    );
        int v;
        v = int'(b);
        if (v > DEPTH) v = DEPTH;
        return IDX_W'(v);
    endfunction

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xsum;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            word_idx       <= '0;
            n_words        <= '0;
            byte_cnt       <= '0;
            asm_q          <= '0;
            mem.imem_we    <= 1'b0;
            mem.imem_addr  <= '0;
            mem.imem_wdata <= '0;
            cpu_hold       <= 1'b0;
            cpu_restart    <= 1'b0;
            done           <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xsum           <= '0;
            err            <= 1'b0;
`endif
        end else begin
            mem.imem_we <= 1'b0;
            cpu_restart <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_evt) begin
                        state    <= HDR;
                        word_idx <= '0;
                        byte_cnt <= '0;
                        asm_q    <= '0;
                        done     <= 1'b0;
                        cpu_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum     <= '0;
                        err      <= 1'b0;
`endif
                    end
                end
                HDR: begin
                    if (byte_evt) begin
                        n_words <= clamp_len(byte_in);
                        if (byte_in == '0) begin
                            state       <= FIN;
                            cpu_hold    <= 1'b0;
                            cpu_restart <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (byte_evt) begin
                        asm_q    <= {byte_in, asm_q[23:8]};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum     <= xsum ^ byte_in;
`endif
                        if (byte_cnt == 2'(WORD_BYTES - 1)) begin
                            mem.imem_we    <= 1'b1;
                            mem.imem_addr  <= word_idx[ADDR_W-1:0];
                            mem.imem_wdata <= {byte_in, asm_q};
                            state          <= WR;
                        end
                    end
                end
                WR: begin
                    word_idx <= word_idx + IDX_W'(1);
                    if (word_idx == n_words - IDX_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state       <= CHK;
`else
                        state       <= FIN;
                        cpu_hold    <= 1'b0;
                        cpu_restart <= 1'b1;
                        done        <= 1'b1;
`endif
                    end else begin
                        state <= DATA;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (byte_evt) begin
                        err         <= (byte_in != xsum);
                        state       <= FIN;
                        cpu_hold    <= 1'b0;
                        cpu_restart <= 1'b1;
                        done        <= 1'b1;
                    end
                end
`endif
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef IMEM_LOADER_CHECKSUM_EN
    assign err = 1'b0;
`endif
endmodule
